// File: rtl/display_pkg.sv
// Shared types and defaults for the seven-segment scan controller and the board top.
package display_pkg;

    localparam int DIG_W                = 4;
    localparam int DEFAULT_SHOW_CYCLES  = 4096;
    localparam int DEFAULT_BLANK_CYCLES = 64;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Loadable down-counter that stops at zero and flags it.
module display_scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Optional leading-zero suppression is enabled by defining DISPLAY_SCANNER_LZ_BLANK_EN.
module display_scanner
    import display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SHOW_CYCLES  = DEFAULT_SHOW_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIG_W*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]       dots,
    input  logic                    update,
    output logic [DIG_W-1:0]        dig,
    output logic                    dp_n,
    output logic [DIGITS-1:0]       an_n,
    output logic                    frame_done
);

    localparam int TW = $clog2(max_int(SHOW_CYCLES, BLANK_CYCLES) + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
    localparam logic [TW-1:0] SHOW_LOAD  = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);

    scan_state_t state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic [TW-1:0] load_value;
    logic          timer_zero;
    logic          wrap;

    logic [DIG_W*DIGITS-1:0] active_value, pending_value;
    logic [DIGITS-1:0]       active_dots, pending_dots;
    logic                    pending_valid;

    logic [DIGITS-1:0] suppress;
    logic [DIGITS-1:0] an_n_next;
    logic              dp_n_next;
    logic [DIG_W-1:0]  cur_nibble;

    // The timer reloads on every state change, so its zero flag doubles as the load strobe.
    display_scan_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_zero),
        .load_value(load_value),
        .zero      (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BLANK;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load_value = BLANK_LOAD;
        wrap       = 1'b0;
        if (timer_zero) begin
            case (state)
                ST_BLANK: begin
                    state_next = ST_SHOW;
                    load_value = SHOW_LOAD;
                end
                ST_SHOW: begin
                    state_next = ST_BLANK;
                    load_value = BLANK_LOAD;
                    if (idx == LAST_IDX) begin
                        idx_next = '0;
                        wrap     = 1'b1;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_BLANK;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Display data only changes on a frame wrap; an update landing on the wrap bypasses pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_value  <= '0;
            active_dots   <= '0;
            pending_value <= '0;
            pending_dots  <= '0;
            pending_valid <= 1'b0;
        end else if (wrap && update) begin
            active_value  <= value;
            active_dots   <= dots;
            pending_valid <= 1'b0;
        end else begin
            if (wrap && pending_valid) begin
                active_value  <= pending_value;
                active_dots   <= pending_dots;
                pending_valid <= 1'b0;
            end
            if (update) begin
                pending_value <= value;
                pending_dots  <= dots;
                pending_valid <= 1'b1;
            end
        end
    end

`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
    always_comb begin
        logic lead;
        lead     = 1'b1;
        suppress = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead        = lead & (active_value[i*DIG_W +: DIG_W] == '0) & ~active_dots[i];
            suppress[i] = lead;
        end
    end
`else
    assign suppress = '0;
`endif

    assign cur_nibble = active_value[int'(idx)*DIG_W +: DIG_W];

    always_comb begin
        an_n_next = '1;
        dp_n_next = 1'b1;
        if (state == ST_SHOW && !suppress[idx]) begin
            an_n_next[idx] = 1'b0;
            dp_n_next      = ~active_dots[idx];
        end
    end

    // The nibble is refreshed while dark so the external decoder settles before the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig        <= '0;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            an_n       <= an_n_next;
            dp_n       <= dp_n_next;
            frame_done <= wrap;
            if (state == ST_BLANK) begin
                dig <= cur_nibble;
            end
        end
    end

endmodule
